// File: rtl/winner_policy_if.sv
// Bus between the routing-decision stage and its environment: upstream
// handshake, node-memory read port and the decision outputs.
interface winner_policy_if #(
    parameter int unsigned WORD_WIDTH = 16
);
    logic                  start;
    logic [WORD_WIDTH-1:0] besthop;
    logic [WORD_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0] data_in;
    logic [WORD_WIDTH-1:0] nexthop;
    logic                  explored;
    logic                  done;

    modport master (
        output start, besthop, data_in,
        input  address, nexthop, explored, done
    );

    modport slave (
        input  start, besthop, data_in,
        output address, nexthop, explored, done
    );
endinterface

// File: rtl/winner_policy.sv
// Epsilon-greedy next-hop selection: exploit the upstream besthop, or explore
// a pseudo-random entry of the betterneighbors table read from node memory.
module winner_policy #(
    parameter int unsigned           WORD_WIDTH      = 16,
    parameter logic [7:0]            EPSILON         = 8'd26,
    parameter logic [7:0]            LFSR_SEED       = 8'hA5,
    parameter logic [WORD_WIDTH-1:0] BETTER_BASE     = 16'h0668,
    parameter logic [WORD_WIDTH-1:0] BETTER_CNT_ADDR = 16'h068C,
    parameter int unsigned           MAX_BETTER      = 16
) (
    input  logic            clock,
    input  logic            rst,
    winner_policy_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_BETTER + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BETTER);

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        CNT_WAIT,
        DRAW,
        MOD,
        RD_NB,
        NB_WAIT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] nexthop_q, nexthop_d;
    logic                  explored_q, explored_d;
    logic                  done_q, done_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic                  lfsr_fb;

    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            nexthop_q  <= '0;
            explored_q <= 1'b0;
            done_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nexthop_q  <= nexthop_d;
            explored_q <= explored_d;
            done_q     <= done_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nexthop_d  = nexthop_q;
        explored_d = explored_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;

        unique case (state_q)
            IDLE: begin
                addr_d = '0;
                if (bus.start) begin
                    state_d = RD_CNT;
                    addr_d  = BETTER_CNT_ADDR;
                end
            end
            RD_CNT: state_d = CNT_WAIT;
            CNT_WAIT: begin
                if (bus.data_in > WORD_WIDTH'(MAX_BETTER)) begin
                    cnt_d = MAX_CNT;
                end else begin
                    cnt_d = bus.data_in[CW-1:0];
                end
                state_d = DRAW;
            end
            DRAW: begin
                lfsr_d = {lfsr_q[6:0], lfsr_fb};
                if ((lfsr_q < EPSILON) && (cnt_q != '0)) begin
                    idx_d   = CW'(lfsr_q[3:0]);
                    state_d = MOD;
                end else begin
                    nexthop_d  = bus.besthop;
                    explored_d = 1'b0;
                    state_d    = DONE;
                end
            end
            // Modulo by repeated subtraction, one step per cycle
            MOD: begin
                if (idx_q >= cnt_q) begin
                    idx_d = idx_q - cnt_q;
                end else begin
                    addr_d  = BETTER_BASE + (WORD_WIDTH'(idx_q) << 1);
                    state_d = RD_NB;
                end
            end
            RD_NB: state_d = NB_WAIT;
            NB_WAIT: begin
                nexthop_d  = bus.data_in;
                explored_d = 1'b1;
                state_d    = DONE;
            end
            DONE: state_d = DONE;
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase

        done_d = (state_d == DONE);
    end

    assign bus.address  = addr_q;
    assign bus.nexthop  = nexthop_q;
    assign bus.explored = explored_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_winner_policy.sv
// Directed bench for winner_policy: three parameterisations share one memory
// model; expected decisions are queued at stimulus time and popped at done.
module tb_winner_policy;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    winner_policy_if ifa ();
    winner_policy_if ifb ();
    winner_policy_if ifc ();

    winner_policy dut_a (.clock(clock), .rst(rst), .bus(ifa));
    winner_policy #(.EPSILON(8'hFF)) dut_b (.clock(clock), .rst(rst), .bus(ifb));
    winner_policy #(.EPSILON(8'hFF), .LFSR_SEED(8'h0F)) dut_c (.clock(clock), .rst(rst), .bus(ifc));

    logic [15:0] tbl [16];
    logic [15:0] cnt_word;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'h0668;
        if (a == 16'h068C) return cnt_word;
        if (a >= 16'h0668 && a < 16'h0688 && !a[0]) return tbl[off[4:1]];
        return 16'hDEAD;
    endfunction

    always @(posedge clock) begin
        ifa.data_in <= mem_rd(ifa.address);
        ifb.data_in <= mem_rd(ifb.address);
        ifc.data_in <= mem_rd(ifc.address);
    end

    typedef struct {
        logic [15:0] nh;
        logic        ex;
        int          lat;
        logic [15:0] addr;
        logic        nb;
        logic [7:0]  lfsr;
    } exp_t;
    exp_t sb[$];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic exp_t predict(input logic [7:0] seed, input logic [7:0] eps,
                                     input logic [15:0] cnt_raw, input logic [15:0] bh);
        exp_t e;
        int unsigned cnt, idx, s;
        cnt    = (cnt_raw > 16) ? 16 : int'(cnt_raw);
        e.lfsr = lfsr_step(seed);
        if (seed < eps && cnt != 0) begin
            idx = int'(seed[3:0]);
            s   = 0;
            while (idx >= cnt) begin
                idx -= cnt;
                s++;
            end
            e.nh   = tbl[idx];
            e.ex   = 1'b1;
            e.lat  = 6 + int'(s);
            e.addr = 16'h0668 + 16'(2 * idx);
            e.nb   = 1'b1;
        end else begin
            e.nh   = bh;
            e.ex   = 1'b0;
            e.lat  = 3;
            e.addr = 16'h068C;
            e.nb   = 1'b0;
        end
        return e;
    endfunction

    task automatic observe(input int sel, output logic d, output logic ex,
                           output logic [15:0] nh, output logic [15:0] ad, output logic [7:0] lf);
        case (sel)
            0: begin d = ifa.done; ex = ifa.explored; nh = ifa.nexthop; ad = ifa.address; lf = dut_a.lfsr_q; end
            1: begin d = ifb.done; ex = ifb.explored; nh = ifb.nexthop; ad = ifb.address; lf = dut_b.lfsr_q; end
            default: begin d = ifc.done; ex = ifc.explored; nh = ifc.nexthop; ad = ifc.address; lf = dut_c.lfsr_q; end
        endcase
    endtask

    task automatic drive(input int sel, input logic st, input logic [15:0] bh);
        case (sel)
            0: begin ifa.start = st; ifa.besthop = bh; end
            1: begin ifb.start = st; ifb.besthop = bh; end
            default: begin ifc.start = st; ifc.besthop = bh; end
        endcase
    endtask

    task automatic reset_all();
        rst = 1'b1;
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        drive(2, 1'b0, 16'h0000);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
    endtask

    task automatic run_txn(input string tag, input int sel, input logic [7:0] seed,
                           input logic [7:0] eps, input logic [15:0] cnt_raw, input logic [15:0] bh);
        exp_t        e;
        logic        d, ex, nb_seen;
        logic [15:0] nh, ad;
        logic [7:0]  lf;
        int          cyc;
        cnt_word = cnt_raw;
        sb.push_back(predict(seed, eps, cnt_raw, bh));
        drive(sel, 1'b1, bh);
        nb_seen = 1'b0;
        cyc     = 0;
        d       = 1'b0;
        while (!d && cyc < 60) begin
            @(negedge clock);
            cyc++;
            observe(sel, d, ex, nh, ad, lf);
            if (ad >= 16'h0668 && ad < 16'h0688) nb_seen = 1'b1;
        end
        e = sb.pop_front();
        check({tag, ".done_seen"}, {31'd0, d}, 32'd1);
        check({tag, ".nexthop"}, {16'd0, nh}, {16'd0, e.nh});
        check({tag, ".explored"}, {31'd0, ex}, {31'd0, e.ex});
        check({tag, ".latency"}, cyc - 1, e.lat);
        check({tag, ".address"}, {16'd0, ad}, {16'd0, e.addr});
        check({tag, ".table_read"}, {31'd0, nb_seen}, {31'd0, e.nb});
        check({tag, ".lfsr"}, {24'd0, lf}, {24'd0, e.lfsr});
    endtask

    initial begin : main
        logic        d, ex;
        logic [15:0] nh, ad;
        logic [7:0]  lf;
        logic [7:0]  seeds [3];
        seeds = '{8'hA5, 8'hA5, 8'h0F};
        for (int i = 0; i < 16; i++) tbl[i] = 16'(i + 1) * 16'h0011;
        cnt_word = 16'd0;

        reset_all();
        for (int s = 0; s < 3; s++) begin
            observe(s, d, ex, nh, ad, lf);
            check("reset.done", {31'd0, d}, 32'd0);
            check("reset.nexthop", {16'd0, nh}, 32'd0);
            check("reset.explored", {31'd0, ex}, 32'd0);
            check("reset.address", {16'd0, ad}, 32'd0);
            check("reset.lfsr", {24'd0, lf}, {24'd0, seeds[s]});
        end

        run_txn("exploit", 0, 8'hA5, 8'd26, 16'd3, 16'h0007);
        reset_all();
        run_txn("explore", 1, 8'hA5, 8'hFF, 16'd3, 16'h0005);
        reset_all();
        run_txn("cnt_zero", 1, 8'hA5, 8'hFF, 16'd0, 16'h0009);
        reset_all();
        run_txn("clamp40", 2, 8'h0F, 8'hFF, 16'd40, 16'h0001);
        reset_all();
        run_txn("cnt16", 2, 8'h0F, 8'hFF, 16'd16, 16'h0001);
        reset_all();
        run_txn("no_route", 0, 8'hA5, 8'd26, 16'd5, 16'hFFFF);

        // Abort while the modulo loop is running, then rerun from scratch.
        reset_all();
        cnt_word = 16'd3;
        drive(1, 1'b1, 16'h0005);
        repeat (4) @(negedge clock);
        observe(1, d, ex, nh, ad, lf);
        check("abort.pre_lfsr", {24'd0, lf}, {24'd0, lfsr_step(8'hA5)});
        rst = 1'b1;
        drive(1, 1'b0, 16'h0005);
        @(negedge clock);
        observe(1, d, ex, nh, ad, lf);
        check("abort.done", {31'd0, d}, 32'd0);
        check("abort.nexthop", {16'd0, nh}, 32'd0);
        check("abort.address", {16'd0, ad}, 32'd0);
        check("abort.lfsr", {24'd0, lf}, 32'hA5);
        rst = 1'b0;
        @(negedge clock);
        run_txn("rerun", 1, 8'hA5, 8'hFF, 16'd3, 16'h0005);

        // start stays high after done: everything must stay frozen.
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            observe(1, d, ex, nh, ad, lf);
            check("hold.done", {31'd0, d}, 32'd1);
            check("hold.nexthop", {16'd0, nh}, 32'h0033);
            check("hold.address", {16'd0, ad}, 32'h066C);
            check("hold.lfsr", {24'd0, lf}, {24'd0, lfsr_step(8'hA5)});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
